// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and defaults for the ALU command sequencer.
// Holds the state encoding plus the default command bytes and widths.
package alu_seq_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int FUN_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [7:0] CMD_OPR_DEF  = 8'hCC;
    localparam logic [7:0] CMD_NOPR_DEF = 8'hDD;

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        GET_FUN,
        ALU_RUN,
        ALU_WAIT,
        TX_SEND
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundles the RX byte path, the ALU control/result path and the TX byte path.
// master = sequencer side, slave = the RX/ALU/TX environment around it.
interface alu_cmd_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int FUN_WIDTH  = FUN_W_DEF
);
    logic [DATA_WIDTH-1:0] RX_D;
    logic                  RX_D_VLD;
    logic [DATA_WIDTH-1:0] ALU_OUT;
    logic                  ALU_OUT_VLD;
    logic                  TX_READY;
    logic [DATA_WIDTH-1:0] ALU_A;
    logic [DATA_WIDTH-1:0] ALU_B;
    logic [FUN_WIDTH-1:0]  ALU_FUN;
    logic                  ALU_EN;
    logic [DATA_WIDTH-1:0] TX_D;
    logic                  TX_D_VLD;
    logic                  BUSY;
    logic                  CMD_ERR;

    modport master (
        input  RX_D, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_READY,
        output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_D, TX_D_VLD, BUSY, CMD_ERR
    );

    modport slave (
        output RX_D, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_READY,
        input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_D, TX_D_VLD, BUSY, CMD_ERR
    );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Parses CC/DD command frames from the RX byte stream, fires the shared ALU once
// and returns its result on TX; every output comes straight from a flop.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DATA_W_DEF,
    parameter int                    FUN_WIDTH   = FUN_W_DEF,
    parameter int                    TIMEOUT_CYC = TIMEOUT_DEF,
    parameter logic [DATA_WIDTH-1:0] CMD_OPR     = CMD_OPR_DEF,
    parameter logic [DATA_WIDTH-1:0] CMD_NOPR    = CMD_NOPR_DEF
) (
    input logic                 CLK,
    input logic                 RST,
    alu_cmd_sequencer_if.master bus
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    seq_state_e            state_q, state_nxt;
    logic [DATA_WIDTH-1:0] a_q, a_nxt;
    logic [DATA_WIDTH-1:0] b_q, b_nxt;
    logic [FUN_WIDTH-1:0]  fun_q, fun_nxt;
    logic                  en_q, en_nxt;
    logic [DATA_WIDTH-1:0] txd_q, txd_nxt;
    logic                  txv_q, txv_nxt;
    logic                  busy_q, busy_nxt;
    logic                  err_q, err_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            en_q    <= 1'b0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            fun_q   <= fun_nxt;
            en_q    <= en_nxt;
            txd_q   <= txd_nxt;
            txv_q   <= txv_nxt;
            busy_q  <= busy_nxt;
            err_q   <= err_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        fun_nxt   = fun_q;
        en_nxt    = 1'b0;
        txd_nxt   = txd_q;
        txv_nxt   = txv_q;
        err_nxt   = 1'b0;
        cnt_nxt   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_D == CMD_OPR)       state_nxt = GET_A;
                    else if (bus.RX_D == CMD_NOPR) state_nxt = GET_FUN;
                    else                           err_nxt   = 1'b1;
                end
            end
            GET_A: begin
                if (bus.RX_D_VLD) begin
                    a_nxt     = bus.RX_D;
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (bus.RX_D_VLD) begin
                    b_nxt     = bus.RX_D;
                    state_nxt = GET_FUN;
                end
            end
            GET_FUN: begin
                if (bus.RX_D_VLD) begin
                    // A function byte with high bits set is malformed; operands already loaded stay put
                    if (|bus.RX_D[DATA_WIDTH-1:FUN_WIDTH]) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        fun_nxt   = bus.RX_D[FUN_WIDTH-1:0];
                        en_nxt    = 1'b1;
                        state_nxt = ALU_RUN;
                    end
                end
            end
            ALU_RUN: begin
                cnt_nxt   = '0;
                state_nxt = ALU_WAIT;
            end
            ALU_WAIT: begin
                if (cnt_q != CNT_MAX) cnt_nxt = cnt_q + 1'b1;
                // Result is checked first so a valid on the expiry cycle still wins
                if (bus.ALU_OUT_VLD) begin
                    txd_nxt   = bus.ALU_OUT;
                    txv_nxt   = 1'b1;
                    state_nxt = TX_SEND;
                end else if (cnt_q == CNT_MAX - 1'b1) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            TX_SEND: begin
                if (bus.TX_READY) begin
                    txv_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.ALU_A    = a_q;
    assign bus.ALU_B    = b_q;
    assign bus.ALU_FUN  = fun_q;
    assign bus.ALU_EN   = en_q;
    assign bus.TX_D     = txd_q;
    assign bus.TX_D_VLD = txv_q;
    assign bus.BUSY     = busy_q;
    assign bus.CMD_ERR  = err_q;

endmodule
